// File: rtl/vga_scanout.sv
// vga_scanout: reads the 160x120x3-bit framebuffer and scans it out to a
// 640x480@60Hz VGA DAC. Each stored pixel is replicated 4x4. A two-stage
// pipeline (address, then data) keeps colour, syncs and blanking aligned.
// A one-clk frame_start pulse marks the wrap back to (h=0, v=0).
module vga_scanout #(
    parameter int H_ACTIVE    = 640,
    parameter int H_FP        = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int V_ACTIVE    = 480,
    parameter int V_FP        = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33,
    parameter int SCALE_SHIFT = 2,
    parameter int FB_W        = 160
) (
    input  logic        clk,
    input  logic        resetn,       // active-high synchronous reset
    output logic [14:0] fb_addr,
    input  logic [2:0]  fb_data,
    output logic        frame_start,
    output logic        VGA_CLK,
    output logic        VGA_HS,
    output logic        VGA_VS,
    output logic        VGA_BLANK_N,
    output logic        VGA_SYNC_N,
    output logic [9:0]  VGA_R,
    output logic [9:0]  VGA_G,
    output logic [9:0]  VGA_B
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0]  H_ACT_END = 10'(H_ACTIVE);
    localparam logic [9:0]  HS_BEGIN  = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0]  HS_END    = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0]  H_LAST    = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_ACT_END = 10'(V_ACTIVE);
    localparam logic [9:0]  VS_BEGIN  = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0]  VS_END    = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [9:0]  V_LAST    = 10'(V_TOTAL - 1);
    localparam logic [14:0] FB_STRIDE = 15'(FB_W);

    // Pixel-rate enable and pixel clock
    logic        pix_en_q;
    logic        vga_clk_q;

    // Scan counters
    logic [9:0]  h_cnt_q, h_cnt_d;
    logic [9:0]  v_cnt_q, v_cnt_d;
    logic        frame_start_q, frame_start_d;

    // Address stage
    logic        s1_active_q, s1_hs_q, s1_vs_q;
    logic [14:0] fb_addr_q, fb_addr_d;
    logic        active_d, hs_raw_d, vs_raw_d;

    // Data stage (drives the DAC)
    logic        blank_n_q, hs_q, vs_q;
    logic [9:0]  r_q, g_q, b_q;

    // Framebuffer coordinates of the current scan position
    logic [14:0] fb_row, fb_col, stride_addr;

    assign fb_row = 15'(v_cnt_q >> SCALE_SHIFT);
    assign fb_col = 15'(h_cnt_q >> SCALE_SHIFT);

    // Row stride: 160 = 128 + 32, so two shifts and an add replace a multiplier.
    generate
        if (FB_W == 160) begin : g_stride_160
            assign stride_addr = (fb_row << 7) + (fb_row << 5) + fb_col;
        end else begin : g_stride_generic
            assign stride_addr = fb_row * FB_STRIDE + fb_col;
        end
    endgenerate

    // Next scan position and wrap detection; holds unless this is a pixel clk
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        h_cnt_d       = h_cnt_q;
        v_cnt_d       = v_cnt_q;
        frame_start_d = 1'b0;
        if (pix_en_q) begin
            if (h_cnt_q == H_LAST) begin
                h_cnt_d = '0;
                if (v_cnt_q == V_LAST) begin
                    v_cnt_d       = '0;
                    frame_start_d = 1'b1;
                end else begin
                    v_cnt_d = v_cnt_q + 10'd1;
                end
            end else begin
                h_cnt_d = h_cnt_q + 10'd1;
            end
        end
    end

    // Raw timing decode and framebuffer address for the current position
    always_comb begin
        active_d  = (h_cnt_q < H_ACT_END) && (v_cnt_q < V_ACT_END);
        hs_raw_d  = !((h_cnt_q >= HS_BEGIN) && (h_cnt_q < HS_END));
        vs_raw_d  = !((v_cnt_q >= VS_BEGIN) && (v_cnt_q < VS_END));
        fb_addr_d = active_d ? stride_addr : '0;
    end

    // Scan state, address stage and data stage, all advancing on pix_en
    always_ff @(posedge clk) begin
        // NOTE: the whole datapath is reset, not just control, so the DAC sees blank/idle sync while reset is held.
        if (resetn) begin
            pix_en_q      <= 1'b0;
            vga_clk_q     <= 1'b0;
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            frame_start_q <= 1'b0;
            s1_active_q   <= 1'b0;
            s1_hs_q       <= 1'b1;
            s1_vs_q       <= 1'b1;
            fb_addr_q     <= '0;
            blank_n_q     <= 1'b0;
            hs_q          <= 1'b1;
            vs_q          <= 1'b1;
            r_q           <= '0;
            g_q           <= '0;
            b_q           <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            pix_en_q      <= ~pix_en_q;
            vga_clk_q     <= ~pix_en_q;
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            frame_start_q <= frame_start_d;
            if (pix_en_q) begin
                s1_active_q <= active_d;
                s1_hs_q     <= hs_raw_d;
                s1_vs_q     <= vs_raw_d;
                fb_addr_q   <= fb_addr_d;
                blank_n_q   <= s1_active_q;
                hs_q        <= s1_hs_q;
                vs_q        <= s1_vs_q;
                r_q         <= s1_active_q ? {10{fb_data[2]}} : '0;
                g_q         <= s1_active_q ? {10{fb_data[1]}} : '0;
                b_q         <= s1_active_q ? {10{fb_data[0]}} : '0;
            end
        end
    end

    assign fb_addr     = fb_addr_q;
    assign frame_start = frame_start_q;
    assign VGA_CLK     = vga_clk_q;
    assign VGA_HS      = hs_q;
    assign VGA_VS      = vs_q;
    assign VGA_BLANK_N = blank_n_q;
    assign VGA_SYNC_N  = 1'b0;
    assign VGA_R       = r_q;
    assign VGA_G       = g_q;
    assign VGA_B       = b_q;

endmodule

// File: tb/tb_vga_scanout.sv
// tb_vga_scanout: drives vga_scanout with a 1-clk-latency framebuffer model.
// Expected outputs come from a timeline model: the number of clks since the
// last reset edge gives the scan position whose outputs should be visible.
// Vertical timing is shortened so whole frames fit in a short run; the
// horizontal timing and the framebuffer addressing are full-size.
`timescale 1ns/1ps
module tb_vga_scanout;

    localparam int H_TOTAL    = 800;
    localparam int V_ACTIVE   = 8;
    localparam int V_FP       = 1;
    localparam int V_SYNC     = 2;
    localparam int V_BP       = 2;
    localparam int V_TOTAL    = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int FRAME_CLKS = 2 * H_TOTAL * V_TOTAL;

    typedef struct packed {
        logic [14:0] addr;
        logic        fs;
        logic        vclk;
        logic        hs;
        logic        vs;
        logic        blank_n;
        logic        sync_n;
        logic [9:0]  r;
        logic [9:0]  g;
        logic [9:0]  b;
    } vga_obs_t;

    logic        clk = 1'b0;
    logic        resetn = 1'b1;
    logic [14:0] fb_addr;
    logic [2:0]  fb_data = 3'b000;
    logic        frame_start, vga_clk, vga_hs, vga_vs, vga_blank_n, vga_sync_n;
    logic [9:0]  vga_r, vga_g, vga_b;

    logic [2:0]  mem [0:19199];
    int          t = 0;
    int          vectors = 0;
    int          errors = 0;

    vga_scanout #(
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
    ) dut (
        .clk(clk), .resetn(resetn), .fb_addr(fb_addr), .fb_data(fb_data),
        .frame_start(frame_start), .VGA_CLK(vga_clk), .VGA_HS(vga_hs),
        .VGA_VS(vga_vs), .VGA_BLANK_N(vga_blank_n), .VGA_SYNC_N(vga_sync_n),
        .VGA_R(vga_r), .VGA_G(vga_g), .VGA_B(vga_b)
    );

    always #10 clk = ~clk;

    // Framebuffer read port, one clk of latency
    always @(posedge clk) fb_data <= mem[fb_addr];

    // Clks elapsed since the last edge that sampled reset
    always @(posedge clk) begin
        if (resetn) t <= 0;
        else        t <= t + 1;
    end

    task automatic step();
        @(negedge clk);
    endtask

    function automatic vga_obs_t sample();
        vga_obs_t o;
        o.addr = fb_addr; o.fs = frame_start; o.vclk = vga_clk;
        o.hs = vga_hs; o.vs = vga_vs; o.blank_n = vga_blank_n;
        o.sync_n = vga_sync_n; o.r = vga_r; o.g = vga_g; o.b = vga_b;
        return o;
    endfunction

    function automatic vga_obs_t reset_vals();
        vga_obs_t o;
        o = '0;
        o.hs = 1'b1;
        o.vs = 1'b1;
        return o;
    endfunction

    // Pixel k of the scan is held for 2 clks starting at clk 2k; its address
    // shows 2 clks later and its colour/syncs 4 clks later.
    function automatic vga_obs_t model(int tt);
        vga_obs_t e;
        int k, h, v;
        logic [2:0] px;
        e = reset_vals();
        e.vclk = 1'((tt % 2) == 1);
        e.fs   = (tt > 0) && ((tt % FRAME_CLKS) == 0);
        if (tt >= 2) begin
            k = (tt - 2) / 2;
            h = k % H_TOTAL;
            v = (k / H_TOTAL) % V_TOTAL;
            if (h < 640 && v < V_ACTIVE) e.addr = 15'((v / 4) * 160 + h / 4);
        end
        if (tt >= 4) begin
            k = (tt - 4) / 2;
            h = k % H_TOTAL;
            v = (k / H_TOTAL) % V_TOTAL;
            e.hs = !(h >= 656 && h <= 751);
            e.vs = !(v >= V_ACTIVE + V_FP && v < V_ACTIVE + V_FP + V_SYNC);
            if (h < 640 && v < V_ACTIVE) begin
                px = mem[(v / 4) * 160 + h / 4];
                e.blank_n = 1'b1;
                e.r = {10{px[2]}};
                e.g = {10{px[1]}};
                e.b = {10{px[0]}};
            end
        end
        return e;
    endfunction

    function automatic string fmt(vga_obs_t o);
        return $sformatf("addr=%0d fs=%b clk=%b hs=%b vs=%b blank_n=%b sync_n=%b rgb=%h/%h/%h",
                         o.addr, o.fs, o.vclk, o.hs, o.vs, o.blank_n, o.sync_n, o.r, o.g, o.b);
    endfunction

    task automatic test_reset();
        vga_obs_t got;
        resetn = 1'b1;
        repeat (3) begin
            step();
            got = sample();
            vectors++;
            if (got !== reset_vals()) begin
                errors++;
                $display("FAIL reset got %s want %s", fmt(got), fmt(reset_vals()));
            end
        end
    endtask

    task automatic test_colour();
        vga_obs_t got, want;
        for (int i = 0; i < 19200; i++) mem[i] = 3'b101;
        resetn = 1'b1;
        step();
        step();
        resetn = 1'b0;
        repeat (1700) begin
            step();
            got  = sample();
            want = model(t);
            vectors++;
            if (got !== want) begin
                errors++;
                $display("FAIL colour t=%0d got %s want %s", t, fmt(got), fmt(want));
            end
            vectors++;
            if (!got.blank_n && (got.r | got.g | got.b) != 10'd0) begin
                errors++;
                $display("FAIL blank_rgb t=%0d rgb=%h/%h/%h want 0", t, got.r, got.g, got.b);
            end
        end
    endtask

    task automatic test_line_timing();
        int hs_low = 0;
        int blank_hi = 0;
        repeat (1600) begin
            step();
            if (vga_hs === 1'b0) hs_low++;
            if (vga_blank_n === 1'b1) blank_hi++;
        end
        vectors++;
        if (hs_low != 192) begin
            errors++;
            $display("FAIL hs_low_per_line got %0d want 192", hs_low);
        end
        vectors++;
        if (blank_hi != 1280) begin
            errors++;
            $display("FAIL blank_high_per_line got %0d want 1280", blank_hi);
        end
    endtask

    task automatic test_addressing();
        int ah [4] = '{3, 4, 700, 639};
        int av [4] = '{3, 4, 5, 7};
        int ae [4] = '{0, 161, 0, 319};
        int target;
        for (int i = 0; i < 4; i++) begin
            target = 2 * (av[i] * H_TOTAL + ah[i]) + 2;
            for (int g = 0; g < 20000 && t < target; g++) step();
            vectors++;
            if (t != target) begin
                errors++;
                $display("FAIL addr_timing h=%0d v=%0d t=%0d want %0d", ah[i], av[i], t, target);
            end else if (fb_addr !== 15'(ae[i])) begin
                errors++;
                $display("FAIL addr h=%0d v=%0d got %0d want %0d", ah[i], av[i], fb_addr, ae[i]);
            end
        end
    endtask

    task automatic test_random_scan();
        vga_obs_t got, want;
        for (int i = 0; i < 19200; i++) mem[i] = 3'($urandom());
        resetn = 1'b1;
        repeat ($urandom_range(1, 3)) step();
        resetn = 1'b0;
        repeat (FRAME_CLKS + 100) begin
            step();
            got  = sample();
            want = model(t);
            vectors++;
            if (got !== want) begin
                errors++;
                $display("FAIL scan t=%0d got %s want %s", t, fmt(got), fmt(want));
            end
        end
    endtask

    task automatic test_frame_timing();
        int vs_low = 0;
        bit seen = 1'b0;
        for (int i = 0; i < 2 * FRAME_CLKS && !seen; i++) begin
            step();
            if (vga_vs === 1'b0) vs_low++;
            if (frame_start === 1'b1) seen = 1'b1;
        end
        vectors++;
        if (!seen || t != 2 * FRAME_CLKS) begin
            errors++;
            $display("FAIL frame_period seen=%0d t=%0d want %0d", seen, t, 2 * FRAME_CLKS);
        end
        vectors++;
        if (vs_low != V_SYNC * 2 * H_TOTAL) begin
            errors++;
            $display("FAIL vs_low_per_frame got %0d want %0d", vs_low, V_SYNC * 2 * H_TOTAL);
        end
        step();
        vectors++;
        if (frame_start !== 1'b0) begin
            errors++;
            $display("FAIL frame_start_width got %b want 0", frame_start);
        end
    endtask

    task automatic test_reset_midline();
        vga_obs_t got, want;
        int target = 2 * FRAME_CLKS + 2 * (3 * H_TOTAL + 300);
        bit fell = 1'b0;
        for (int g = 0; g < 20000 && t < target; g++) step();
        vectors++;
        if (t != target) begin
            errors++;
            $display("FAIL midline_reach t=%0d want %0d", t, target);
        end
        resetn = 1'b1;
        repeat (2) begin
            step();
            got = sample();
            vectors++;
            if (got !== reset_vals()) begin
                errors++;
                $display("FAIL midline_reset got %s want %s", fmt(got), fmt(reset_vals()));
            end
        end
        resetn = 1'b0;
        for (int i = 0; i < 2000 && !fell; i++) begin
            step();
            got  = sample();
            want = model(t);
            vectors++;
            if (got !== want) begin
                errors++;
                $display("FAIL restart t=%0d got %s want %s", t, fmt(got), fmt(want));
            end
            if (vga_hs === 1'b0) begin
                fell = 1'b1;
                vectors++;
                if (t != 4 + 2 * 656) begin
                    errors++;
                    $display("FAIL first_hs_fall got %0d clks want %0d", t, 4 + 2 * 656);
                end
            end
        end
        if (!fell) begin
            vectors++;
            errors++;
            $display("FAIL first_hs_fall got none within 2000 clks want %0d", 4 + 2 * 656);
        end
    endtask

    initial begin
        for (int i = 0; i < 19200; i++) mem[i] = 3'b000;
        test_reset();
        test_colour();
        test_line_timing();
        test_addressing();
        test_random_scan();
        test_frame_timing();
        test_reset_midline();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
